// File: rtl/fifo_rx_fsm.sv
// FT232H 245-FIFO receive side: RXF#/RD# read handshake plus 5-byte command packet parser.
// Packet = [SYNC][CMD][ARG_HI][ARG_LO][CHK], CHK = CMD ^ ARG_HI ^ ARG_LO.
module fifo_rx_fsm #(
  parameter int unsigned RD_LOW_CYCLES  = 3,
  parameter int unsigned RD_HIGH_CYCLES = 3,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int unsigned TIMEOUT_CYCLES = 5000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rxf_n,
  input  logic [7:0]  data_in,
  input  logic        enable,
  output logic        rd_n,
  output logic [7:0]  cmd,
  output logic [15:0] arg,
  output logic        cmd_valid,
  output logic        chk_err,
  output logic        timeout_err,
  output logic [1:0]  state
);

  localparam int unsigned RD_MAX = (RD_LOW_CYCLES > RD_HIGH_CYCLES) ? RD_LOW_CYCLES : RD_HIGH_CYCLES;
  localparam int unsigned RC_W   = $clog2(RD_MAX + 1);
  localparam int unsigned TO_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [RC_W-1:0] RD_LOW_LAST  = RC_W'(RD_LOW_CYCLES - 1);
  localparam logic [RC_W-1:0] RD_HIGH_LAST = RC_W'(RD_HIGH_CYCLES - 1);
  localparam logic [TO_W-1:0] TO_LIMIT     = TO_W'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RD_LOW  = 2'd1,
    S_RD_HIGH = 2'd2,
    S_UNUSED  = 2'd3
  } state_t;

  state_t          cur_state, nxt_state;
  logic [RC_W-1:0] rd_cnt, rd_cnt_nxt;
  logic            latch_c;
  logic            rxf_meta, rxf_sync;
  logic [7:0]      byte_reg;
  logic            byte_stb;
  logic [2:0]      idx;
  logic [7:0]      cmd_sh, hi_sh, lo_sh;
  logic [TO_W-1:0] to_cnt;

  assign state = cur_state;

  // RXF# crosses in asynchronously from the FT232H
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rxf_meta <= 1'b1;
      rxf_sync <= 1'b1;
    end else begin
      rxf_meta <= rxf_n;
      rxf_sync <= rxf_meta;
    end
  end

  // Read FSM state register; rd_n is registered from the next state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_state <= S_IDLE;
      rd_cnt    <= '0;
      rd_n      <= 1'b1;
      byte_reg  <= '0;
      byte_stb  <= 1'b0;
    end else begin
      cur_state <= nxt_state;
      rd_cnt    <= rd_cnt_nxt;
      rd_n      <= (nxt_state != S_RD_LOW);
      byte_stb  <= latch_c;
      if (latch_c) byte_reg <= data_in;
    end
  end

  // Read FSM next state: fixed-length low strobe then fixed recovery
  always_comb begin
    nxt_state  = cur_state;
    rd_cnt_nxt = rd_cnt;
    latch_c    = 1'b0;
    case (cur_state)
      S_IDLE: begin
        rd_cnt_nxt = '0;
        if (!rxf_sync && enable) nxt_state = S_RD_LOW;
      end
      S_RD_LOW: begin
        if (rd_cnt == RD_LOW_LAST) begin
          nxt_state  = S_RD_HIGH;
          rd_cnt_nxt = '0;
          latch_c    = 1'b1;
        end else begin
          rd_cnt_nxt = rd_cnt + RC_W'(1);
        end
      end
      S_RD_HIGH: begin
        if (rd_cnt == RD_HIGH_LAST) begin
          nxt_state  = S_IDLE;
          rd_cnt_nxt = '0;
        end else begin
          rd_cnt_nxt = rd_cnt + RC_W'(1);
        end
      end
      default: begin
        nxt_state  = S_IDLE;
        rd_cnt_nxt = '0;
      end
    endcase
  end

  // Packet parser and inter-byte timeout; a byte always wins over a timeout
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx         <= '0;
      cmd_sh      <= '0;
      hi_sh       <= '0;
      lo_sh       <= '0;
      cmd         <= '0;
      arg         <= '0;
      cmd_valid   <= 1'b0;
      chk_err     <= 1'b0;
      timeout_err <= 1'b0;
      to_cnt      <= '0;
    end else begin
      cmd_valid   <= 1'b0;
      chk_err     <= 1'b0;
      timeout_err <= 1'b0;
      if (byte_stb) begin
        to_cnt <= '0;
        case (idx)
          3'd0: if (byte_reg == SYNC_BYTE) idx <= 3'd1;
          3'd1: begin cmd_sh <= byte_reg; idx <= 3'd2; end
          3'd2: begin hi_sh  <= byte_reg; idx <= 3'd3; end
          3'd3: begin lo_sh  <= byte_reg; idx <= 3'd4; end
          default: begin
            if (byte_reg == (cmd_sh ^ hi_sh ^ lo_sh)) begin
              cmd       <= cmd_sh;
              arg       <= {hi_sh, lo_sh};
              cmd_valid <= 1'b1;
            end else begin
              chk_err <= 1'b1;
            end
            idx <= 3'd0;
          end
        endcase
      end else if (idx == 3'd0) begin
        to_cnt <= '0;
      end else if (to_cnt == TO_LIMIT) begin
        idx         <= 3'd0;
        timeout_err <= 1'b1;
        to_cnt      <= '0;
      end else begin
        to_cnt <= to_cnt + TO_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_fifo_rx_fsm.sv
// Bench for fifo_rx_fsm: FT232H host model, per-cycle packet reference model, directed + random scenarios.
module tb_fifo_rx_fsm;

  localparam int T = 100;
  localparam int RD_LOW = 3;

  typedef logic [7:0] bq_t[$];

  logic        clk = 1'b0;
  logic        reset;
  logic        rxf_n;
  logic [7:0]  data_in;
  logic        enable;
  logic        rd_n;
  logic [7:0]  cmd;
  logic [15:0] arg;
  logic        cmd_valid;
  logic        chk_err;
  logic        timeout_err;
  logic [1:0]  state;

  int errors = 0;
  int checks = 0;
  int cnt_valid = 0, cnt_chk = 0, cnt_to = 0, rd_falls = 0, rd_rises = 0;

  // reference model state
  logic [7:0]  din_at_edge = '0;
  logic [7:0]  mq[$];
  logic [7:0]  m_cmd = '0;
  logic [15:0] m_arg = '0;
  bit          pend = 0;
  logic [7:0]  pend_byte = '0;
  logic        prev_rd = 1'b1;
  int          gap = 0, low_len = 0, high_len = 100;
  bit          e_v, e_c, e_t;
  bq_t         seq;

  always #5 clk = ~clk;

  fifo_rx_fsm #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .reset(reset), .rxf_n(rxf_n), .data_in(data_in), .enable(enable),
    .rd_n(rd_n), .cmd(cmd), .arg(arg), .cmd_valid(cmd_valid), .chk_err(chk_err),
    .timeout_err(timeout_err), .state(state)
  );

  // data present on the bus at each rising edge (the latch edge of a read)
  initial forever begin
    @(posedge clk);
    din_at_edge = data_in;
  end

  // Per-cycle reference: bytes are consumed when RD# returns high; packets judged by checksum rule
  initial forever begin
    @(negedge clk);
    if (reset !== 1'b0) begin
      mq.delete(); m_cmd = '0; m_arg = '0; pend = 0; prev_rd = 1'b1;
      gap = 0; low_len = 0; high_len = 100;
    end else begin
      e_v = 0; e_c = 0; e_t = 0;
      gap++;
      if (pend) begin
        pend = 0;
        if (mq.size() == 0) begin
          if (pend_byte == 8'hA5) mq.push_back(pend_byte);
        end else begin
          mq.push_back(pend_byte);
          if (mq.size() == 5) begin
            if ((mq[1] ^ mq[2] ^ mq[3]) == mq[4]) begin
              m_cmd = mq[1]; m_arg = {mq[2], mq[3]}; e_v = 1;
            end else e_c = 1;
            mq.delete();
          end
        end
      end else if (mq.size() != 0 && gap == T + 2) begin
        e_t = 1; mq.delete();
      end
      checks += 6;
      if (cmd_valid !== e_v) begin errors++; $display("FAIL cmd_valid @%0t: got %b want %b", $time, cmd_valid, e_v); end
      if (chk_err !== e_c) begin errors++; $display("FAIL chk_err @%0t: got %b want %b", $time, chk_err, e_c); end
      if (timeout_err !== e_t) begin errors++; $display("FAIL timeout_err @%0t: got %b want %b", $time, timeout_err, e_t); end
      if (cmd !== m_cmd) begin errors++; $display("FAIL cmd @%0t: got %h want %h", $time, cmd, m_cmd); end
      if (arg !== m_arg) begin errors++; $display("FAIL arg @%0t: got %h want %h", $time, arg, m_arg); end
      if ((state === 2'd1) !== (rd_n === 1'b0)) begin
        errors++; $display("FAIL state_vs_rd_n @%0t: state=%0d rd_n=%b", $time, state, rd_n);
      end
      if (prev_rd && !rd_n) begin
        rd_falls++; checks++;
        if (high_len < 3) begin errors++; $display("FAIL rd_high_len: got %0d want >=3", high_len); end
        low_len = 0;
      end
      if (!prev_rd && rd_n) begin
        rd_rises++; checks++;
        if (low_len != RD_LOW) begin errors++; $display("FAIL rd_low_len: got %0d want %0d", low_len, RD_LOW); end
        pend = 1; pend_byte = din_at_edge; gap = 0; high_len = 0;
      end
      if (!rd_n) low_len++; else high_len++;
      prev_rd = rd_n;
      if (cmd_valid === 1'b1) cnt_valid++;
      if (chk_err === 1'b1) cnt_chk++;
      if (timeout_err === 1'b1) cnt_to++;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b, input int pre);
    bit ok;
    if (pre > 0) begin
      rxf_n = 1'b1;
      repeat (pre) @(negedge clk);
    end
    data_in = b;
    rxf_n = 1'b0;
    ok = 0;
    for (int i = 0; i < 300 && !ok; i++) begin @(negedge clk); if (rd_n === 1'b0) ok = 1; end
    checks++;
    if (!ok) begin errors++; $display("FAIL read_start: rd_n=%b, want 0 within 300 clks", rd_n); end
    else begin
      ok = 0;
      for (int i = 0; i < 20 && !ok; i++) begin @(negedge clk); if (rd_n === 1'b1) ok = 1; end
      checks++;
      if (!ok) begin errors++; $display("FAIL read_end: rd_n=%b, want 1 within 20 clks", rd_n); end
    end
  endtask

  task automatic send_seq(input bq_t bs, input int pre_first);
    foreach (bs[i]) send_byte(bs[i], (i == 0) ? pre_first : 0);
    rxf_n = 1'b1;
    repeat (12) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; rxf_n = 1'b1; enable = 1'b1; data_in = 8'h00;
    repeat (3) @(negedge clk);
    checks += 4;
    if (rd_n !== 1'b1) begin errors++; $display("FAIL reset_rd_n: got %b want 1", rd_n); end
    if (cmd !== 8'h00 || arg !== 16'h0000) begin errors++; $display("FAIL reset_cmd_arg: got %h/%h want 00/0000", cmd, arg); end
    if ({cmd_valid, chk_err, timeout_err} !== 3'b000) begin errors++; $display("FAIL reset_pulses: got %b want 000", {cmd_valid, chk_err, timeout_err}); end
    if (state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", state); end
    @(posedge clk); #2 reset = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_single_packet();
    int v0, r0;
    v0 = cnt_valid; r0 = rd_rises;
    seq = '{8'hA5, 8'h12, 8'h03, 8'hE8, 8'hF9};
    send_seq(seq, 2);
    checks += 3;
    if (cnt_valid - v0 != 1) begin errors++; $display("FAIL single_valid_count: got %0d want 1", cnt_valid - v0); end
    if (rd_rises - r0 != 5) begin errors++; $display("FAIL single_reads: got %0d want 5", rd_rises - r0); end
    if (cmd !== 8'h12 || arg !== 16'h03E8) begin errors++; $display("FAIL single_cmd_arg: got %h/%h want 12/03E8", cmd, arg); end
  endtask

  task automatic test_resync();
    int v0;
    v0 = cnt_valid;
    seq = '{8'h00, 8'h7F, 8'hA5, 8'h01, 8'h00, 8'h10, 8'h11};
    send_seq(seq, 2);
    checks += 2;
    if (cnt_valid - v0 != 1) begin errors++; $display("FAIL resync_valid_count: got %0d want 1", cnt_valid - v0); end
    if (cmd !== 8'h01 || arg !== 16'h0010) begin errors++; $display("FAIL resync_cmd_arg: got %h/%h want 01/0010", cmd, arg); end
  endtask

  task automatic test_chk_err();
    int v0, c0;
    v0 = cnt_valid; c0 = cnt_chk;
    seq = '{8'hA5, 8'h01, 8'h00, 8'h10, 8'hFF};
    send_seq(seq, 2);
    checks += 3;
    if (cnt_chk - c0 != 1) begin errors++; $display("FAIL chk_count: got %0d want 1", cnt_chk - c0); end
    if (cnt_valid - v0 != 0) begin errors++; $display("FAIL chk_no_valid: got %0d want 0", cnt_valid - v0); end
    if (cmd !== 8'h01 || arg !== 16'h0010) begin errors++; $display("FAIL chk_hold: got %h/%h want 01/0010", cmd, arg); end
  endtask

  task automatic test_timeout();
    int v0, t0;
    t0 = cnt_to;
    seq = '{8'hA5, 8'h01};
    send_seq(seq, 2);
    repeat (150) @(negedge clk);
    checks++;
    if (cnt_to - t0 != 1) begin errors++; $display("FAIL timeout_count: got %0d want 1", cnt_to - t0); end
    v0 = cnt_valid;
    seq = '{8'hA5, 8'h12, 8'h03, 8'hE8, 8'hF9};
    send_seq(seq, 2);
    checks += 2;
    if (cnt_valid - v0 != 1) begin errors++; $display("FAIL after_timeout_valid: got %0d want 1", cnt_valid - v0); end
    if (cmd !== 8'h12 || arg !== 16'h03E8) begin errors++; $display("FAIL after_timeout_cmd_arg: got %h/%h want 12/03E8", cmd, arg); end
    // byte lands on the last allowed cycle: packet survives
    v0 = cnt_valid; t0 = cnt_to;
    send_byte(8'hA5, 2); send_byte(8'h01, 0);
    send_byte(8'h00, T - 5); send_byte(8'h10, 0); send_byte(8'h11, 0);
    rxf_n = 1'b1; repeat (12) @(negedge clk);
    checks += 3;
    if (cnt_to - t0 != 0) begin errors++; $display("FAIL edge_no_timeout: got %0d want 0", cnt_to - t0); end
    if (cnt_valid - v0 != 1) begin errors++; $display("FAIL edge_valid: got %0d want 1", cnt_valid - v0); end
    if (cmd !== 8'h01 || arg !== 16'h0010) begin errors++; $display("FAIL edge_cmd_arg: got %h/%h want 01/0010", cmd, arg); end
    // one cycle later: timeout wins, remaining bytes are hunted past
    v0 = cnt_valid; t0 = cnt_to;
    send_byte(8'hA5, 2); send_byte(8'h02, 0);
    send_byte(8'h00, T - 4); send_byte(8'h10, 0); send_byte(8'h12, 0);
    rxf_n = 1'b1; repeat (12) @(negedge clk);
    checks += 2;
    if (cnt_to - t0 != 1) begin errors++; $display("FAIL late_timeout: got %0d want 1", cnt_to - t0); end
    if (cnt_valid - v0 != 0) begin errors++; $display("FAIL late_no_valid: got %0d want 0", cnt_valid - v0); end
  endtask

  task automatic test_enable();
    int f0, r0;
    bit ok;
    f0 = rd_falls;
    enable = 1'b0; data_in = 8'h00; rxf_n = 1'b0;
    repeat (40) @(negedge clk);
    checks += 2;
    if (rd_falls - f0 != 0) begin errors++; $display("FAIL enable_hold_reads: got %0d want 0", rd_falls - f0); end
    if (rd_n !== 1'b1) begin errors++; $display("FAIL enable_hold_rd_n: got %b want 1", rd_n); end
    f0 = rd_falls; r0 = rd_rises;
    enable = 1'b1;
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin @(negedge clk); if (rd_n === 1'b0) ok = 1; end
    enable = 1'b0;
    repeat (40) @(negedge clk);
    checks += 4;
    if (!ok) begin errors++; $display("FAIL enable_read_start: rd_n=%b want 0", rd_n); end
    if (rd_falls - f0 != 1) begin errors++; $display("FAIL enable_drop_reads: got %0d want 1", rd_falls - f0); end
    if (rd_rises - r0 != 1) begin errors++; $display("FAIL enable_drop_complete: got %0d want 1", rd_rises - r0); end
    if (rd_n !== 1'b1) begin errors++; $display("FAIL enable_drop_rd_n: got %b want 1", rd_n); end
    rxf_n = 1'b1; enable = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_reset_mid_read();
    int v0;
    bit ok;
    send_byte(8'hA5, 2); send_byte(8'h12, 0);
    data_in = 8'h03;
    ok = 0;
    for (int i = 0; i < 30 && !ok; i++) begin @(negedge clk); if (rd_n === 1'b0) ok = 1; end
    @(posedge clk); #2 reset = 1'b1;
    #1;
    checks += 5;
    if (!ok) begin errors++; $display("FAIL midread_start: rd_n=%b want 0", rd_n); end
    if (rd_n !== 1'b1) begin errors++; $display("FAIL midread_rd_n: got %b want 1", rd_n); end
    if (cmd !== 8'h00 || arg !== 16'h0000) begin errors++; $display("FAIL midread_cmd_arg: got %h/%h want 00/0000", cmd, arg); end
    if ({cmd_valid, chk_err, timeout_err} !== 3'b000) begin errors++; $display("FAIL midread_pulses: got %b want 000", {cmd_valid, chk_err, timeout_err}); end
    if (state !== 2'd0) begin errors++; $display("FAIL midread_state: got %0d want 0", state); end
    rxf_n = 1'b1;
    repeat (3) @(negedge clk);
    @(posedge clk); #2 reset = 1'b0;
    repeat (3) @(negedge clk);
    v0 = cnt_valid;
    seq = '{8'hA5, 8'h12, 8'h03, 8'hE8, 8'hF9};
    send_seq(seq, 2);
    checks += 2;
    if (cnt_valid - v0 != 1) begin errors++; $display("FAIL post_reset_valid: got %0d want 1", cnt_valid - v0); end
    if (cmd !== 8'h12 || arg !== 16'h03E8) begin errors++; $display("FAIL post_reset_cmd_arg: got %h/%h want 12/03E8", cmd, arg); end
  endtask

  task automatic test_random();
    int v0;
    logic [7:0] c, hi, lo, k, junk;
    int pre;
    v0 = cnt_valid;
    for (int p = 0; p < 40; p++) begin
      c = 8'($urandom_range(0, 255)); hi = 8'($urandom_range(0, 255)); lo = 8'($urandom_range(0, 255));
      k = c ^ hi ^ lo;
      if ($urandom_range(0, 3) == 0) k = k ^ 8'($urandom_range(1, 255));
      if ($urandom_range(0, 4) == 0) begin
        junk = 8'($urandom_range(0, 255));
        if (junk == 8'hA5) junk = 8'h00;
        send_byte(junk, $urandom_range(0, 6));
      end
      send_byte(8'hA5, $urandom_range(0, 6));
      seq = '{c, hi, lo, k};
      foreach (seq[i]) begin
        pre = ($urandom_range(0, 9) == 0) ? $urandom_range(T - 8, T + 8) : $urandom_range(0, 4);
        send_byte(seq[i], pre);
      end
    end
    rxf_n = 1'b1;
    repeat (T + 20) @(negedge clk);
    checks++;
    if (cnt_valid - v0 < 1) begin errors++; $display("FAIL random_any_valid: got %0d want >=1", cnt_valid - v0); end
  endtask

  initial begin
    test_reset();
    test_single_packet();
    test_resync();
    test_chk_err();
    test_timeout();
    test_enable();
    test_reset_mid_read();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
